// File: rtl/fp32_vec_compare.sv
// Streaming FP32 vector compare, exact or ULP-tolerance, LANES elements per beat.
// Optional macro FP32_CMP_TRACE_EN: sim-only mismatch trace plus parameter sanity check.

package utils;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, READY = 2'd2} state;
endpackage

module fp32_vec_compare #(
  parameter int VEC_LEN = 16,
  parameter int LANES   = 4,
  parameter int IDX_W   = $clog2(VEC_LEN),
  parameter int CNT_W   = $clog2(VEC_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode_ulp,
  input  logic [7:0]            tol,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*32-1:0]   a_data,
  input  logic [LANES*32-1:0]   b_data,
  output logic                  busy,
  output logic                  done,
  output logic                  equal,
  output logic [CNT_W-1:0]      mismatch_cnt,
  output logic                  first_valid,
  output logic [IDX_W-1:0]      first_idx
);
  import utils::*;

  // state | meaning
  // IDLE  | after reset, no results
  // WAIT  | accepting beats, then draining the 2-stage pipeline
  // READY | results valid, held until the next start

  localparam int BEATS = VEC_LEN / LANES;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;

  state               r_state;
  logic               r_mode_ulp;
  logic [7:0]         r_tol;
  logic [BCW-1:0]     r_beat_cnt;
  logic               r_in_ready;
  logic               r_s1_valid;
  logic               r_s1_last;
  logic [LANES-1:0]   r_s1_flags;
  logic [BCW-1:0]     r_s1_beat;
  logic               r_s2_last;
  logic               r_done;
  logic               r_equal;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_first_valid;
  logic [IDX_W-1:0]   r_first_idx;

  logic               w_accept;
  logic               w_last_beat;
  logic [LANES-1:0]   w_flags;
  logic [CNT_W-1:0]   w_pop;
  logic [IDX_W-1:0]   w_lane;
  logic [IDX_W-1:0]   w_idx;

  // Sign-magnitude to two's complement ordering; 34 bits so |a-b| cannot wrap at +-max.
  function automatic logic [33:0] f_ulp_diff(input logic [31:0] a, input logic [31:0] b);
    logic signed [33:0] v_oa;
    logic signed [33:0] v_ob;
    logic signed [33:0] v_d;
    v_oa = $signed({3'b000, a[30:0]});
    v_ob = $signed({3'b000, b[30:0]});
    if (a[31]) v_oa = -v_oa;
    if (b[31]) v_ob = -v_ob;
    v_d = v_oa - v_ob;
    if (v_d < 0) v_d = -v_d;
    return v_d;
  endfunction

  function automatic logic f_mismatch(input logic [31:0] a, input logic [31:0] b,
                                      input logic ulp, input logic [7:0] t);
    logic v_nan;
    logic v_mis;
    v_nan = (&a[30:23] && |a[22:0]) || (&b[30:23] && |b[22:0]);
    if (v_nan)
      v_mis = 1'b1;
    else if (ulp)
      v_mis = f_ulp_diff(a, b) > {26'd0, t};
    else
      v_mis = !((a[30:0] == 31'd0 && b[30:0] == 31'd0) || a == b);
    return v_mis;
  endfunction

  assign w_accept    = in_valid && r_in_ready;
  assign w_last_beat = (r_beat_cnt == BCW'(BEATS - 1));

  always_comb begin
    w_flags = '0;
    for (int i = 0; i < LANES; i++)
      w_flags[i] = f_mismatch(a_data[32*i +: 32], b_data[32*i +: 32], r_mode_ulp, r_tol);
  end

  always_comb begin
    w_pop  = '0;
    w_lane = '0;
    for (int i = LANES - 1; i >= 0; i--)
      if (r_s1_flags[i]) w_lane = IDX_W'(i);
    for (int i = 0; i < LANES; i++)
      w_pop = w_pop + CNT_W'(r_s1_flags[i]);
  end

  assign w_idx = IDX_W'(r_s1_beat) * IDX_W'(LANES) + w_lane;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_mode_ulp    <= 1'b0;
      r_tol         <= '0;
      r_beat_cnt    <= '0;
      r_in_ready    <= 1'b0;
      r_s1_valid    <= 1'b0;
      r_s1_last     <= 1'b0;
      r_s1_flags    <= '0;
      r_s1_beat     <= '0;
      r_s2_last     <= 1'b0;
      r_done        <= 1'b0;
      r_equal       <= 1'b0;
      r_cnt         <= '0;
      r_first_valid <= 1'b0;
      r_first_idx   <= '0;
    end else begin
      r_done     <= 1'b0;
      r_s1_valid <= w_accept;
      r_s1_last  <= w_accept && w_last_beat;
      r_s2_last  <= r_s1_valid && r_s1_last;
      if (w_accept) begin
        r_s1_flags <= w_flags;
        r_s1_beat  <= r_beat_cnt;
        r_beat_cnt <= r_beat_cnt + 1'b1;
        if (w_last_beat) r_in_ready <= 1'b0;
      end
      if (r_s1_valid) begin
        r_cnt <= r_cnt + w_pop;
        // Earliest beat wins; later mismatches never overwrite.
        if (!r_first_valid && |r_s1_flags) begin
          r_first_valid <= 1'b1;
          r_first_idx   <= w_idx;
        end
      end
      case (r_state)
        IDLE, READY: begin
          if (start) begin
            r_state       <= WAIT;
            r_mode_ulp    <= mode_ulp;
            r_tol         <= tol;
            r_beat_cnt    <= '0;
            r_in_ready    <= 1'b1;
            r_equal       <= 1'b0;
            r_cnt         <= '0;
            r_first_valid <= 1'b0;
            r_first_idx   <= '0;
          end
        end
        WAIT: begin
          if (r_s2_last) begin
            r_state <= READY;
            r_done  <= 1'b1;
            r_equal <= (r_cnt == '0);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign busy         = (r_state == WAIT);
  assign done         = r_done;
  assign equal        = r_equal;
  assign mismatch_cnt = r_cnt;
  assign first_valid  = r_first_valid;
  assign first_idx    = r_first_idx;

`ifdef FP32_CMP_TRACE_EN
  logic [LANES*32-1:0] r_s1_a;
  logic [LANES*32-1:0] r_s1_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_a <= '0;
      r_s1_b <= '0;
    end else if (w_accept) begin
      r_s1_a <= a_data;
      r_s1_b <= b_data;
    end
  end

  always @(posedge clk) begin
    if (!rst && r_s1_valid) begin
      for (int i = 0; i < LANES; i++) begin
        if (r_s1_flags[i])
          $display("fp32_vec_compare: mismatch idx=%0d a=%08h b=%08h mode=%s diff=%0d",
                   int'(r_s1_beat) * LANES + i, r_s1_a[32*i +: 32], r_s1_b[32*i +: 32],
                   r_mode_ulp ? "ulp" : "exact", f_ulp_diff(r_s1_a[32*i +: 32], r_s1_b[32*i +: 32]));
      end
    end
  end

  if (LANES < 1 || (VEC_LEN % LANES) != 0) begin : g_param_chk
    $error("fp32_vec_compare: VEC_LEN must be a multiple of LANES and LANES >= 1");
  end
`endif

endmodule

// File: tb/tb_fp32_vec_compare.sv
// Table-driven bench for fp32_vec_compare with a result scoreboard and
// hand-written reset / restart sequences.

module tb_fp32_vec_compare;
  localparam int VEC_LEN = 16;
  localparam int LANES   = 4;
  localparam int BEATS   = VEC_LEN / LANES;
  localparam int NV      = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         mode_ulp;
  logic [7:0]   tol;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] a_data;
  logic [127:0] b_data;
  logic         busy;
  logic         done;
  logic         equal;
  logic [4:0]   mismatch_cnt;
  logic         first_valid;
  logic [3:0]   first_idx;

  always #5 clk = ~clk;

  fp32_vec_compare #(.VEC_LEN(VEC_LEN), .LANES(LANES)) dut (
    .clk(clk), .rst(rst), .start(start), .mode_ulp(mode_ulp), .tol(tol),
    .in_valid(in_valid), .in_ready(in_ready), .a_data(a_data), .b_data(b_data),
    .busy(busy), .done(done), .equal(equal), .mismatch_cnt(mismatch_cnt),
    .first_valid(first_valid), .first_idx(first_idx)
  );

  typedef struct {
    logic              mode;
    logic [7:0]        tol;
    logic              tgl;
    logic              inj;
    logic [15:0][31:0] a;
    logic [15:0][31:0] b;
    logic              e_eq;
    logic [4:0]        e_cnt;
    logic              e_fv;
    logic [3:0]        e_idx;
  } vec_t;

  typedef struct packed {
    logic       eq;
    logic [4:0] cnt;
    logic       fv;
    logic [3:0] idx;
  } res_t;

  vec_t vecs[NV];
  res_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int k, input logic m, input logic [7:0] t, input logic tg,
                         input logic inj, input logic eq, input logic [4:0] c,
                         input logic fv, input logic [3:0] ix);
    vecs[k].mode  = m;
    vecs[k].tol   = t;
    vecs[k].tgl   = tg;
    vecs[k].inj   = inj;
    vecs[k].e_eq  = eq;
    vecs[k].e_cnt = c;
    vecs[k].e_fv  = fv;
    vecs[k].e_idx = ix;
    for (int j = 0; j < VEC_LEN; j++) begin
      vecs[k].a[j] = 32'h3F80_0000 + 32'(j);
      vecs[k].b[j] = 32'h3F80_0000 + 32'(j);
    end
  endtask

  task automatic run_vec(input int vi);
    vec_t v;
    res_t r;
    int   b;
    int   cyc;
    int   rdy_cnt;
    int   wait_n;
    logic acc;
    v = vecs[vi];
    b = 0;
    cyc = 0;
    rdy_cnt = 0;
    sb_q.push_back({v.e_eq, v.e_cnt, v.e_fv, v.e_idx});
    start    = 1'b1;
    mode_ulp = v.mode;
    tol      = v.tol;
    in_valid = 1'b0;
    tick();
    start    = 1'b0;
    mode_ulp = ~v.mode;
    tol      = 8'h00;
    chk($sformatf("v%0d_clr_equal", vi), equal, 0);
    chk($sformatf("v%0d_clr_cnt", vi), mismatch_cnt, 0);
    chk($sformatf("v%0d_clr_fv", vi), first_valid, 0);
    chk($sformatf("v%0d_busy", vi), busy, 1);
    while (b < BEATS && cyc < 64) begin
      in_valid = v.tgl ? (cyc % 2 == 0) : 1'b1;
      a_data   = v.a[b*LANES +: LANES];
      b_data   = v.b[b*LANES +: LANES];
      start    = v.inj && (b == 1);
      if (in_ready) rdy_cnt++;
      acc = in_valid && in_ready;
      tick();
      cyc++;
      if (acc) b++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    chk($sformatf("v%0d_beats_accepted", vi), b, BEATS);
    if (!v.tgl) chk($sformatf("v%0d_ready_cycles", vi), rdy_cnt, BEATS);
    chk($sformatf("v%0d_ready_drop", vi), in_ready, 0);
    wait_n = 0;
    while (!done && wait_n < 10) begin
      tick();
      wait_n++;
    end
    chk($sformatf("v%0d_done_latency", vi), wait_n, 2);
    r = sb_q.pop_front();
    if (done) begin
      chk($sformatf("v%0d_equal", vi), equal, r.eq);
      chk($sformatf("v%0d_cnt", vi), mismatch_cnt, r.cnt);
      chk($sformatf("v%0d_first_valid", vi), first_valid, r.fv);
      chk($sformatf("v%0d_first_idx", vi), first_idx, r.idx);
      chk($sformatf("v%0d_busy_ready", vi), busy, 0);
    end
    tick();
    chk($sformatf("v%0d_done_pulse", vi), done, 0);
    chk($sformatf("v%0d_cnt_hold", vi), mismatch_cnt, r.cnt);
    chk($sformatf("v%0d_equal_hold", vi), equal, r.eq);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int dcount;

    // v0: all 1.0, exact, in_valid held
    set_vec(0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 4'd0);
    for (int j = 0; j < VEC_LEN; j++) begin
      vecs[0].a[j] = 32'h3F80_0000;
      vecs[0].b[j] = 32'h3F80_0000;
    end
    // v1: +0 vs -0 match, NaN vs identical NaN mismatch; start pulsed mid-WAIT
    set_vec(1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1, 4'd9);
    vecs[1].a[5] = 32'h0000_0000; vecs[1].b[5] = 32'h8000_0000;
    vecs[1].a[9] = 32'h7FC0_0000; vecs[1].b[9] = 32'h7FC0_0000;
    // v2: ULP tol=2, diff 2 match, diff 3 mismatch
    set_vec(2, 1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 4'd12);
    vecs[2].a[3]  = 32'h3F80_0000; vecs[2].b[3]  = 32'h3F80_0002;
    vecs[2].a[12] = 32'h3F80_0000; vecs[2].b[12] = 32'h3F80_0003;
    // v3/v4: across zero, diff 2 with tol 2 then tol 1
    set_vec(3, 1'b1, 8'd2, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 4'd0);
    vecs[3].a[0] = 32'h0000_0001; vecs[3].b[0] = 32'h8000_0001;
    set_vec(4, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 4'd0);
    vecs[4].a[0] = 32'h0000_0001; vecs[4].b[0] = 32'h8000_0001;
    // v5: exact, mismatches at 14, 6, 7 with toggling in_valid
    set_vec(5, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 5'd3, 1'b1, 4'd6);
    vecs[5].a[14] = 32'h0000_0000; vecs[5].b[14] = 32'h0000_0001;
    vecs[5].a[6]  = 32'h3F80_0000; vecs[5].b[6]  = 32'h3F80_0001;
    vecs[5].a[7]  = 32'h3F80_0000; vecs[5].b[7]  = 32'hBF80_0000;
    // v6: ULP tol=255: +inf/-inf, inf/inf, NaN, +max/-max
    set_vec(6, 1'b1, 8'd255, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 4'd2);
    vecs[6].a[2]  = 32'h7F80_0000; vecs[6].b[2]  = 32'hFF80_0000;
    vecs[6].a[4]  = 32'h7F80_0000; vecs[6].b[4]  = 32'h7F80_0000;
    vecs[6].a[10] = 32'h7FC0_0000; vecs[6].b[10] = 32'h7FC0_0000;
    vecs[6].a[15] = 32'h7F7F_FFFF; vecs[6].b[15] = 32'hFF7F_FFFF;
    // v7: ULP tol=255 boundary, diff 255 match, diff 256 mismatch
    set_vec(7, 1'b1, 8'd255, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 4'd11);
    vecs[7].a[8]  = 32'h3F80_0000; vecs[7].b[8]  = 32'h3F80_00FF;
    vecs[7].a[11] = 32'h3F80_0000; vecs[7].b[11] = 32'h3F80_0100;
    // v8: two mismatches in one beat, lowest lane wins
    set_vec(8, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1, 4'd1);
    vecs[8].b[3] = 32'h4000_0000;
    vecs[8].b[1] = 32'h4000_0000;
    // v9: every element differs, count reaches VEC_LEN
    set_vec(9, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 5'd16, 1'b1, 4'd0);
    for (int j = 0; j < VEC_LEN; j++) vecs[9].b[j] = 32'hC000_0000;

    rst      = 1'b1;
    start    = 1'b0;
    mode_ulp = 1'b0;
    tol      = 8'h00;
    in_valid = 1'b0;
    a_data   = '0;
    b_data   = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_outputs", {equal, mismatch_cnt, first_valid, first_idx}, 0);

    for (int k = 0; k < NV; k++) run_vec(k);

    // Reset in the middle of WAIT with partial results accumulated.
    start    = 1'b1;
    mode_ulp = 1'b0;
    tol      = 8'h00;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    a_data   = {4{32'h3F80_0000}};
    b_data   = {32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 32'h3F80_0000};
    tick();
    b_data   = {4{32'h3F80_0000}};
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("mid_cnt", mismatch_cnt, 1);
    chk("mid_first_valid", first_valid, 1);
    chk("mid_first_idx", first_idx, 1);
    chk("mid_busy", busy, 1);
    chk("mid_in_ready", in_ready, 1);
    #3 rst = 1'b1;
    #1;
    chk("arst_in_ready", in_ready, 0);
    chk("arst_busy", busy, 0);
    chk("arst_outputs", {done, equal, mismatch_cnt, first_valid, first_idx}, 0);
    tick();
    rst = 1'b0;
    dcount = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (done) dcount++;
    end
    chk("arst_no_done", dcount, 0);
    chk("arst_idle_busy", busy, 0);
    chk("arst_idle_ready", in_ready, 0);

    run_vec(4);
    chk("sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
